// File: rtl/spi_aes_frame_ctrl.sv
// Byte-level sequencer between the SPI slave byte port and the AES core: command parse,
// key/block assembly, AES start, result readback. Optional key reuse under AES_KEY_CACHE_EN.
module spi_aes_frame_ctrl #(
  parameter int          KEY_BYTES = 16,
  parameter int          BLK_BYTES = 16,
  parameter logic [7:0]  CMD_ENC   = 8'h01,
  parameter logic [7:0]  CMD_DEC   = 8'h02
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_n,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_rx,
  output logic [7:0]             byte_tx,
  output logic [8*KEY_BYTES-1:0] aes_key,
  output logic [8*BLK_BYTES-1:0] aes_block,
  output logic                   aes_mode,
  output logic                   aes_start,
  input  logic                   aes_done,
  input  logic [8*BLK_BYTES-1:0] aes_result,
  output logic                   busy,
  output logic                   frame_err,
  output logic [2:0]             state_dbg
);

  // Handshakes: byte_valid, aes_start and aes_done are single-cycle strobes with no
  // backpressure; a strobe is consumed in the cycle it is high or not at all.

  localparam int KW   = 8 * KEY_BYTES;
  localparam int BW   = 8 * BLK_BYTES;
  localparam int MAXB = (KEY_BYTES > BLK_BYTES) ? KEY_BYTES : BLK_BYTES;
  localparam int CW   = $clog2(MAXB + 1);
  localparam logic [CW-1:0] KEY_LAST = CW'(KEY_BYTES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLK_BYTES - 1);

`ifdef AES_KEY_CACHE_EN
  localparam logic [7:0] CMD_ENC_C = CMD_ENC | 8'h10;
  localparam logic [7:0] CMD_DEC_C = CMD_DEC | 8'h10;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_KEY   = 3'd2,
    S_DATA  = 3'd3,
    S_RUN   = 3'd4,
    S_RESP  = 3'd5,
    S_DRAIN = 3'd6
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [BW-1:0]   tx_buf, tx_n;
  logic [KW-1:0]   key_n;
  logic [BW-1:0]   blk_n;
  logic            mode_n, err_n, start_n, busy_n;
  logic [7:0]      byte_tx_n;
`ifdef AES_KEY_CACHE_EN
  logic            key_valid, kv_n;
`endif

  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tx_n      = tx_buf;
    key_n     = aes_key;
    blk_n     = aes_block;
    mode_n    = aes_mode;
    err_n     = frame_err;
    start_n   = 1'b0;
    busy_n    = 1'b0;
    byte_tx_n = 8'h00;
`ifdef AES_KEY_CACHE_EN
    kv_n      = key_valid;
`endif

    case (state)
      S_IDLE: begin
        if (!cs_n) state_n = S_CMD;
      end
      S_CMD: begin
        if (byte_valid) begin
          if (byte_rx == CMD_ENC || byte_rx == CMD_DEC) begin
            mode_n  = (byte_rx == CMD_DEC);
            err_n   = 1'b0;
            cnt_n   = '0;
            state_n = S_KEY;
          end
`ifdef AES_KEY_CACHE_EN
          else if ((byte_rx == CMD_ENC_C || byte_rx == CMD_DEC_C) && key_valid) begin
            mode_n  = (byte_rx == CMD_DEC_C);
            err_n   = 1'b0;
            cnt_n   = '0;
            state_n = S_DATA;
          end
`endif
          else begin
            err_n   = 1'b1;
            state_n = S_DRAIN;
          end
        end
      end
      S_KEY: begin
        if (byte_valid) begin
          key_n = {aes_key[KW-9:0], byte_rx};
          if (cnt == KEY_LAST) begin
            cnt_n   = '0;
            state_n = S_DATA;
`ifdef AES_KEY_CACHE_EN
            kv_n    = 1'b1;
`endif
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (byte_valid) begin
          blk_n = {aes_block[BW-9:0], byte_rx};
          if (cnt == BLK_LAST) begin
            cnt_n   = '0;
            state_n = S_RUN;
            start_n = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      S_RUN: begin
        // A done coinciding with our own start pulse cannot belong to this operation.
        if (aes_done && !aes_start) begin
          tx_n    = aes_result;
          cnt_n   = '0;
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        if (byte_valid) begin
          tx_n = {tx_buf[BW-9:0], 8'h00};
          if (cnt == BLK_LAST) begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cs_n) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Abort runs after the byte was taken, so a byte that completes DATA still starts AES.
    if (cs_n && (state_n == S_CMD || state_n == S_KEY || state_n == S_DATA)) begin
`ifdef AES_KEY_CACHE_EN
      if (state_n == S_KEY) kv_n = 1'b0;
`endif
      state_n = S_IDLE;
      err_n   = 1'b1;
    end

    busy_n = (state_n == S_RUN);
    // Status bit 6 (in RESP) is never visible here because RESP shows result bytes instead.
    if (state_n == S_RESP) byte_tx_n = tx_n[BW-1 -: 8];
    else                   byte_tx_n = {busy_n, 1'b0, err_n, 5'b00000};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tx_buf    <= '0;
      aes_key   <= '0;
      aes_block <= '0;
      aes_mode  <= 1'b0;
      aes_start <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      byte_tx   <= 8'h00;
`ifdef AES_KEY_CACHE_EN
      key_valid <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tx_buf    <= tx_n;
      aes_key   <= key_n;
      aes_block <= blk_n;
      aes_mode  <= mode_n;
      aes_start <= start_n;
      busy      <= busy_n;
      frame_err <= err_n;
      byte_tx   <= byte_tx_n;
`ifdef AES_KEY_CACHE_EN
      key_valid <= kv_n;
`endif
    end
  end

endmodule

// File: tb/tb_spi_aes_frame_ctrl.sv
// Bench for spi_aes_frame_ctrl: directed frames with literal expectations, then random frames
// checked every cycle against a frame-level model. Define AES_KEY_CACHE_EN to cover key reuse.
module tb_spi_aes_frame_ctrl;

  logic         clk = 1'b0;
  logic         reset, cs_n, byte_valid, aes_done;
  logic [7:0]   byte_rx, byte_tx;
  logic [127:0] aes_key, aes_block, aes_result;
  logic         aes_mode, aes_start, busy, frame_err;
  logic [2:0]   state_dbg;

  int checks   = 0;
  int failures = 0;
  int n_start  = 0;

  spi_aes_frame_ctrl dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .byte_valid(byte_valid), .byte_rx(byte_rx),
    .byte_tx(byte_tx), .aes_key(aes_key), .aes_block(aes_block), .aes_mode(aes_mode),
    .aes_start(aes_start), .aes_done(aes_done), .aes_result(aes_result), .busy(busy),
    .frame_err(frame_err), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

`ifdef AES_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  // ---------------- frame-level model ----------------
  localparam int P_IDLE = 0, P_CMD = 1, P_BODY = 2, P_RUN = 3, P_RESP = 4, P_DRAIN = 5;
  int           m_phase = P_IDLE;
  int           m_need  = 0;   // body bytes expected after the command (32, or 16 with a cached key)
  int           m_got   = 0;
  logic         m_err = 1'b0, m_mode = 1'b0, m_start = 1'b0, m_kv = 1'b0;
  logic [127:0] m_key = '0, m_block = '0;
  logic [7:0]   exp_q[$];      // response bytes still owed to the host

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic nstart;
    nstart = 1'b0;
    if (reset) begin
      m_phase = P_IDLE; m_err = 1'b0; m_mode = 1'b0; m_kv = 1'b0;
      m_key = '0; m_block = '0; exp_q.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (!cs_n) m_phase = P_CMD;
        P_CMD: if (byte_valid) begin
          if (byte_rx == 8'h01 || byte_rx == 8'h02) begin
            m_mode = (byte_rx == 8'h02); m_err = 1'b0; m_need = 32; m_got = 0; m_phase = P_BODY;
          end else if (CACHE && (byte_rx == 8'h11 || byte_rx == 8'h12) && m_kv) begin
            m_mode = (byte_rx == 8'h12); m_err = 1'b0; m_need = 16; m_got = 0; m_phase = P_BODY;
          end else begin
            m_err = 1'b1; m_phase = P_DRAIN;
          end
        end
        P_BODY: if (byte_valid) begin
          if (m_got < m_need - 16) m_key = {m_key[119:0], byte_rx};
          else                     m_block = {m_block[119:0], byte_rx};
          m_got++;
          if (m_need == 32 && m_got == 16) m_kv = 1'b1;
          if (m_got == m_need) begin m_phase = P_RUN; nstart = 1'b1; end
        end
        P_RUN: if (aes_done && !m_start) begin
          for (int i = 0; i < 16; i++) exp_q.push_back(aes_result[127-8*i -: 8]);
          m_phase = P_RESP;
        end
        P_RESP: if (byte_valid) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_phase = P_IDLE;
        end
        P_DRAIN: if (cs_n) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
      if (cs_n && (m_phase == P_CMD || m_phase == P_BODY)) begin
        if (m_phase == P_BODY && m_need == 32 && m_got < 16) m_kv = 1'b0;
        m_phase = P_IDLE; m_err = 1'b1;
      end
    end
    m_start = nstart;
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [7:0] exp_tx;
    forever begin
      @(negedge clk);
      if (m_phase == P_RESP && exp_q.size() > 0) exp_tx = exp_q[0];
      else exp_tx = {m_phase == P_RUN, 1'b0, m_err, 5'b00000};
      chk("cyc_byte_tx",   byte_tx,   exp_tx);
      chk("cyc_busy",      busy,      m_phase == P_RUN);
      chk("cyc_frame_err", frame_err, m_err);
      chk("cyc_aes_start", aes_start, m_start);
      chk("cyc_aes_mode",  aes_mode,  m_mode);
      chk("cyc_aes_key",   aes_key,   m_key);
      chk("cyc_aes_block", aes_block, m_block);
      if (aes_start === 1'b1) n_start++;
      model_step();
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b1; byte_rx = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    idle(gap);
  endtask

  task automatic send_block(input logic [127:0] v);
    for (int i = 0; i < 16; i++) send_byte(v[127-8*i -: 8], (i == 15) ? 0 : $urandom_range(0, 2));
  endtask

  task automatic pulse_done(input logic [127:0] res);
    aes_result = res; aes_done = 1'b1;
    idle(1);
    aes_done = 1'b0;
  endtask

  task automatic drain_response();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), $urandom_range(0, 2));
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    summary();
    $finish;
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BLK0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RES0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [7:0] res_b [16];
    int         s0, r, nb;
    logic [7:0] cmd;
    res_b = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
              8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};
    reset = 1'b1; cs_n = 1'b1; byte_valid = 1'b0; byte_rx = 8'h00;
    aes_done = 1'b0; aes_result = '0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;

    chk("rst_byte_tx", byte_tx, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_aes_key", aes_key, 128'h0);

    // Encrypt frame from the reference vector.
    cs_n = 1'b0; idle(1);
    send_byte(8'h01, 1);
    send_block(KEY0);
    send_block(BLK0);
    chk("enc_start_pulse", aes_start, 1'b1);
    chk("enc_key", aes_key, 128'h000102030405060708090a0b0c0d0e0f);
    chk("enc_block", aes_block, 128'h00112233445566778899aabbccddeeff);
    chk("enc_mode", aes_mode, 1'b0);
    chk("enc_stat_run", byte_tx, 8'h80);
    idle(1);
    chk("enc_start_single", aes_start, 1'b0);
    chk("enc_busy", busy, 1'b1);
    pulse_done(RES0);
    chk("enc_busy_fall", busy, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("enc_resp_byte", byte_tx, res_b[i]);
      send_byte(8'hff, (i == 15) ? 0 : $urandom_range(0, 2));
    end
    cs_n = 1'b1;
    chk("enc_stat_after", byte_tx, 8'h00);
    idle(2);

    // Bad command, drain, then a good decrypt command and a key-phase abort.
    cs_n = 1'b0; idle(1);
    send_byte(8'h7e, 0);
    chk("bad_err", frame_err, 1'b1);
    chk("bad_stat", byte_tx, 8'h20);
    for (int i = 0; i < 3; i++) send_byte(8'h01, 1);
    chk("bad_drain_stat", byte_tx, 8'h20);
    cs_n = 1'b1; idle(2);
    cs_n = 1'b0; idle(1);
    send_byte(8'h02, 0);
    chk("dec_err_clear", frame_err, 1'b0);
    chk("dec_mode", aes_mode, 1'b1);
    s0 = n_start;
    for (int i = 0; i < 5; i++) send_byte(8'ha0 + 8'(i), 1);
    cs_n = 1'b1; idle(2);
    chk("abort_err", frame_err, 1'b1);
    chk("abort_stat", byte_tx, 8'h20);
    chk("abort_key_partial", aes_key, 128'h05060708090a0b0c0d0e0fa0a1a2a3a4);
    chk("abort_no_start", n_start, s0);

    // Reset while running; a late done must not open a response.
    cs_n = 1'b0; idle(1);
    send_byte(8'h01, 0);
    send_block(128'h101112131415161718191a1b1c1d1e1f);
    send_block(128'h202122232425262728292a2b2c2d2e2f);
    idle(1);
    chk("rr_busy_before", busy, 1'b1);
    cs_n = 1'b1; reset = 1'b1; idle(1); reset = 1'b0;
    pulse_done(RES0);
    chk("rr_byte_tx", byte_tx, 8'h00);
    chk("rr_busy", busy, 1'b0);
    chk("rr_err", frame_err, 1'b0);
    idle(2);
    chk("rr_no_resp", byte_tx, 8'h00);

    // Cached-key command with no key loaded since reset is refused.
    cs_n = 1'b0; idle(1);
    send_byte(8'h11, 0);
    chk("cache_nokey_err", frame_err, 1'b1);
    cs_n = 1'b1; idle(2);
`ifdef AES_KEY_CACHE_EN
    cs_n = 1'b0; idle(1);
    send_byte(8'h01, 0); send_block(KEY0); send_block(BLK0);
    idle(1); pulse_done(RES0); drain_response();
    cs_n = 1'b1; idle(2);
    cs_n = 1'b0; idle(1);
    send_byte(8'h11, 0);
    send_block(128'hfedcba98765432100123456789abcdef);
    chk("cache_start", aes_start, 1'b1);
    chk("cache_key_reused", aes_key, 128'h000102030405060708090a0b0c0d0e0f);
    chk("cache_err", frame_err, 1'b0);
    idle(1); pulse_done(RES0); drain_response();
    cs_n = 1'b1; idle(2);
`endif

    // Random frames: legal, illegal, cached-key and aborted, with random gaps and cs_n edges.
    for (int f = 0; f < 150; f++) begin
      cs_n = 1'b0; idle($urandom_range(1, 2));
      r = $urandom_range(0, 7);
      if (r < 5)       cmd = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'h01;
      else if (r == 5) cmd = 8'($urandom);
      else if (r == 6) cmd = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h11;
      else             cmd = 8'h01;
      send_byte(cmd, $urandom_range(0, 1));
      nb = cmd[4] ? 16 : 32;
      if (r == 7) nb = $urandom_range(0, 31);
      for (int i = 0; i < nb; i++) begin
        if (i == nb - 1 && $urandom_range(0, 2) == 0) cs_n = 1'b1;
        send_byte(8'($urandom), (i == nb - 1) ? 0 : $urandom_range(0, 2));
      end
      if (m_phase == P_RUN) begin
        if ($urandom_range(0, 2) == 0) pulse_done({$urandom, $urandom, $urandom, $urandom});
        idle($urandom_range(0, 3));
        pulse_done({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 16; i++) begin
          cs_n = 1'($urandom_range(0, 1));
          send_byte(8'($urandom), $urandom_range(0, 2));
        end
      end
      cs_n = 1'b1; idle($urandom_range(1, 3));
    end

    idle(2);
    summary();
    $finish;
  end

endmodule
